nn_layer_engine: RTL and testbench
==================================

# nn_layer_engine

Time-multiplexed, parametrised dense-layer engine for the backpropagation network. It runs one fully connected layer per command. In forward mode it computes y = act(W·x + b) with a single shared multiplier. In update mode it applies the gradient step w -= (δ·x) >> (FW+LR_SHIFT) in place. It replaces the fixed 2-3-2 parallel datapath: the top level instantiates one engine per layer and sequences it with a controller.

## Interface
- N_IN, default 2: inputs per neuron; bias is stored as extra column N_IN.
- N_OUT, default 3: neurons (outputs).
- DW, default 16: signed data width for x, δ, w and y.
- FW, default 10: fraction bits (Q6.10 at defaults; 1.0 = 1024).
- LR_SHIFT, default 3: learning rate = 2^-LR_SHIFT.
- ACT, default 1: 0 = linear; 1 = hard sigmoid, clamp((a>>>2) + 0.5, 0, 1.0).
- clk  in  1  rising-edge clock; the only clock.
- res  in  1  synchronous, active-low reset.
- start  in  1  command strobe; sampled only in IDLE.
- mode  in  2  00 forward, 01 update, 1x reserved.
- x_in  in  N_IN*DW  input vector, element i at bits [i*DW +: DW]; latched on an accepted start.
- delta_in  in  N_OUT*DW  error vector for update mode; latched on an accepted start.
- wr_en  in  1  weight write strobe.
- wr_addr  in  clog2(N_OUT*(N_IN+1))  address = j*(N_IN+1)+i.
- wr_data  in  DW  weight value.
- rd_addr  in  same width as wr_addr  readback address.
- rd_data  out  DW  combinational readback of W[rd_addr]; 0 if the address is out of range.
- busy  out  1  high while a command executes.
- done  out  1  one-cycle pulse when a command completes.
- y_out  out  N_OUT*DW  registered layer output; updated only by forward mode.

## Operation
- FSM states: IDLE, MAC, WB, UPD, FIN.
- IDLE transitions:
  - start=1 with mode=00 → latch x, clear acc, j=i=0, go to MAC.
  - start=1 with mode=01 → latch x and δ, go to UPD.
  - start=1 with reserved mode → ignored; stay in IDLE with no done.
- MAC: acc += (W[j][i]·x_i) >>> FW, with x_N_IN ≡ 1.0.
  - Shift is arithmetic (floor).
  - acc width is 2·DW + clog2(N_IN+1), so no wrap is possible.
  - After i = N_IN, go to WB.
- WB:
  - Saturate acc to [-2^(DW-1), 2^(DW-1)-1], apply ACT, write y[j].
  - If j = N_OUT-1, go to FIN; otherwise j++, i=0, clear acc, return to MAC.
- UPD: one weight per cycle, j-major then i.
  - W[j][i] ← sat(W[j][i] - ((δ_j·x_i) >>> (FW+LR_SHIFT))).
  - After the last weight, go to FIN.
- FIN: done=1 for this cycle, busy=0; go to IDLE.
- Writes:
  - wr_en is honoured only in IDLE; ignored while busy.
  - Out-of-range wr_addr is ignored.
- Simultaneous wr_en and start in IDLE: the write lands on that same edge, and the command uses the new weight.
- start while busy is ignored and is not queued.
- x_in and delta_in may change freely after the accepting edge.
- Reset (res=0, any state, including mid-command):
  - Next state is IDLE; busy=0, done=0, y_out=0, all weights=0.
  - Any partial update is abandoned. Weights already written keep their pre-reset values until the reset edge clears them.

## Timing
- Accepting edge is t0. busy=1 from t0+1 until FIN.
- Forward mode:
  - busy for N_OUT·(N_IN+2) cycles; done at t0+1+N_OUT·(N_IN+2).
  - At defaults: 12 cycles busy, done at t0+13.
- Update mode:
  - busy for N_OUT·(N_IN+1) cycles; done at t0+1+N_OUT·(N_IN+1).
  - At defaults: 9 cycles busy, done at t0+10.
- y_out[j] changes at its WB edge. All of y_out is stable when done=1.
- Back-to-back: a start in the cycle after done is accepted.
- rd_data has zero latency and reflects a write from the next cycle onward.

## Structure
- Shared package nn_pkg holds:
  - mode and state enums;
  - the ONE constant (1 << FW);
  - the sat_dw and hard_sigmoid functions, reused by future layer variants.
- One sub-module, nn_mac_sat, contains the signed DW×DW multiply, the arithmetic shift by a run-time amount (FW or FW+LR_SHIFT) and the DW saturation. It is shared by the MAC and UPD paths.
- Weights live in a flat register array of N_OUT·(N_IN+1) entries.

## Test plan
- Forward at defaults:
  - Setup: W row 0 = {1024, 1024, 0}, x = {512, 256}.
  - Expected: y0 = 704 (0.6875); done exactly 13 cycles after start; busy high for 12.
- Update at defaults:
  - Setup: W[0][0] = 1024, W[0][2] = 0, δ0 = 512, x0 = 512.
  - Expected: W[0][0] = 992, bias W[0][2] = -64, read via rd_data; done at t0+10.
- Saturation with ACT=0:
  - Setup: W row 0 = {32767, 32767, 32767}, x = {32767, 32767}.
  - Expected: y0 = 32767. Mirrored negatives give -32768.
- Hard-sigmoid clamp: acc = -4096 gives y = 0; acc = 4096 gives y = 1024.
- Protocol:
  - start pulsed while busy → no extra done.
  - mode = 2 → no busy, no done.
  - wr_en while busy → weight unchanged.
  - wr_en with start in the same IDLE cycle → new weight used.
- Reset: assert res=0 at cycle 5 of a forward command. Next cycle must show busy=0, done=0, y_out=0, all rd_data=0, and a fresh command must then run normally.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared types and fixed-point helpers for the dense-layer engines.
// Helpers work on a wide signed carrier so any layer width up to 31 bits can reuse them.
package nn_pkg;

  localparam int WIDE_W = 64;
  typedef logic signed [WIDE_W-1:0] wide_t;

  typedef enum logic [1:0] {
    MODE_FWD = 2'b00,
    MODE_UPD = 2'b01
  } mode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAC,
    S_WB,
    S_UPD,
    S_FIN
  } state_e;

  // Fixed-point 1.0 for a given number of fraction bits.
  function automatic wide_t one_fx(input int fw);
    return wide_t'(1) <<< fw;
  endfunction

  function automatic wide_t sat_dw(input wide_t a, input int dw);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (dw - 1)) - wide_t'(1);
    lo = -(wide_t'(1) <<< (dw - 1));
    if (a > hi) return hi;
    if (a < lo) return lo;
    return a;
  endfunction

  // clamp(a/4 + 0.5, 0, 1.0)
  function automatic wide_t hard_sigmoid(input wide_t a, input int fw);
    wide_t t;
    t = (a >>> 2) + (one_fx(fw) >>> 1);
    if (t < wide_t'(0)) return wide_t'(0);
    if (t > one_fx(fw)) return one_fx(fw);
    return t;
  endfunction

endpackage

// File: rtl/nn_mac_sat.sv
// Shared signed multiplier with run-time arithmetic shift; also produces the
// saturated gradient step base - (a*b >>> sh) for in-place weight updates.
module nn_mac_sat
  import nn_pkg::*;
#(
  parameter int DW  = 16,
  parameter int SHW = 4
) (
  input  logic signed [DW-1:0]   a_i,
  input  logic signed [DW-1:0]   b_i,
  input  logic        [SHW-1:0]  sh_i,
  input  logic signed [DW-1:0]   base_i,
  output logic signed [2*DW-1:0] prod_sh_o,
  output logic signed [DW-1:0]   upd_o
);

  logic signed [2*DW-1:0] prod;
  wide_t                  diff;

  assign prod      = (2*DW)'(a_i) * (2*DW)'(b_i);
  assign prod_sh_o = prod >>> sh_i;
  assign diff      = wide_t'(base_i) - wide_t'(prod_sh_o);
  assign upd_o     = DW'(sat_dw(diff, DW));

endmodule

// File: rtl/nn_layer_engine.sv
// Time-multiplexed dense layer: forward y = act(W*x + b) or in-place gradient
// update, both sequenced over one shared multiplier.
module nn_layer_engine
  import nn_pkg::*;
#(
  parameter int N_IN     = 2,
  parameter int N_OUT    = 3,
  parameter int DW       = 16,
  parameter int FW       = 10,
  parameter int LR_SHIFT = 3,
  parameter int ACT      = 1,
  localparam int NW      = N_OUT * (N_IN + 1),
  localparam int AW      = (NW > 1) ? $clog2(NW) : 1
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [N_IN*DW-1:0]    x_in,
  input  logic [N_OUT*DW-1:0]   delta_in,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DW-1:0]         wr_data,
  input  logic [AW-1:0]         rd_addr,
  output logic [DW-1:0]         rd_data,
  output logic                  busy,
  output logic                  done,
  output logic [N_OUT*DW-1:0]   y_out
);

  localparam int IW   = $clog2(N_IN + 1);
  localparam int JW   = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int ACCW = 2 * DW + IW;
  localparam int SHW  = $clog2(FW + LR_SHIFT + 1);

  state_e                       state_q, state_d;
  logic [IW-1:0]                i_q, i_d;
  logic [JW-1:0]                j_q, j_d;
  logic signed [ACCW-1:0]       acc_q, acc_d;
  logic [N_IN-1:0][DW-1:0]      x_q, x_d;
  logic [N_OUT-1:0][DW-1:0]     dl_q, dl_d;
  logic [N_OUT-1:0][DW-1:0]     y_q, y_d;
  logic [NW-1:0][DW-1:0]        w_q, w_d;

  logic [AW-1:0]                widx;
  logic signed [DW-1:0]         w_cur, x_cur, dl_cur, a_op, upd, y_new;
  logic signed [2*DW-1:0]       prod_sh;
  logic [SHW-1:0]               sh;

  assign widx = AW'(j_q) * AW'(N_IN + 1) + AW'(i_q);

  // Operand steering: column N_IN is the bias, so its input is 1.0.
  always_comb begin
    w_cur = w_q[widx];
    x_cur = DW'(one_fx(FW));
    for (int k = 0; k < N_IN; k++)
      if (i_q == IW'(k)) x_cur = x_q[k];
    dl_cur = '0;
    for (int k = 0; k < N_OUT; k++)
      if (j_q == JW'(k)) dl_cur = dl_q[k];
    a_op  = (state_q == S_UPD) ? dl_cur : w_cur;
    sh    = (state_q == S_UPD) ? SHW'(FW + LR_SHIFT) : SHW'(FW);
    y_new = DW'(sat_dw(wide_t'(acc_q), DW));
    if (ACT == 1) y_new = DW'(hard_sigmoid(sat_dw(wide_t'(acc_q), DW), FW));
  end

  nn_mac_sat #(.DW(DW), .SHW(SHW)) u_mac (
    .a_i       (a_op),
    .b_i       (x_cur),
    .sh_i      (sh),
    .base_i    (w_cur),
    .prod_sh_o (prod_sh),
    .upd_o     (upd)
  );

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    acc_d   = acc_q;
    x_d     = x_q;
    dl_d    = dl_q;
    y_d     = y_q;
    w_d     = w_q;
    case (state_q)
      S_IDLE: begin
        if (wr_en && int'(wr_addr) < NW) w_d[wr_addr] = wr_data;
        if (start && mode == MODE_FWD) begin
          x_d     = x_in;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = S_MAC;
        end else if (start && mode == MODE_UPD) begin
          x_d     = x_in;
          dl_d    = delta_in;
          i_d     = '0;
          j_d     = '0;
          state_d = S_UPD;
        end
      end
      S_MAC: begin
        acc_d = acc_q + ACCW'(prod_sh);
        if (i_q == IW'(N_IN)) state_d = S_WB;
        else                  i_d = i_q + 1'b1;
      end
      S_WB: begin
        for (int k = 0; k < N_OUT; k++)
          if (j_q == JW'(k)) y_d[k] = y_new;
        if (j_q == JW'(N_OUT - 1)) begin
          state_d = S_FIN;
        end else begin
          j_d     = j_q + 1'b1;
          i_d     = '0;
          acc_d   = '0;
          state_d = S_MAC;
        end
      end
      S_UPD: begin
        w_d[widx] = upd;
        if (i_q == IW'(N_IN)) begin
          i_d = '0;
          if (j_q == JW'(N_OUT - 1)) state_d = S_FIN;
          else                       j_d = j_q + 1'b1;
        end else begin
          i_d = i_q + 1'b1;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      acc_q   <= '0;
      x_q     <= '0;
      dl_q    <= '0;
      y_q     <= '0;
      w_q     <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
      dl_q    <= dl_d;
      y_q     <= y_d;
      w_q     <= w_d;
    end
  end

  always_comb begin
    rd_data = '0;
    if (int'(rd_addr) < NW) rd_data = w_q[rd_addr];
  end

  assign busy  = (state_q == S_MAC) || (state_q == S_WB) || (state_q == S_UPD);
  assign done  = (state_q == S_FIN);
  assign y_out = y_q;

endmodule

// File: tb/tb_nn_layer_engine.sv
// Directed bench: hard-sigmoid and linear engines share all inputs so one
// stimulus stream checks both activation variants.
module tb_nn_layer_engine;

  logic        clk = 1'b0;
  logic        res = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [31:0] x_in = '0;
  logic [47:0] delta_in = '0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic [3:0]  rd_addr = '0;
  logic [15:0] rd_s, rd_l;
  logic        busy_s, busy_l, done_s, done_l;
  logic [47:0] y_s, y_l;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nn_layer_engine u_sig (
    .clk(clk), .res(res), .start(start), .mode(mode), .x_in(x_in),
    .delta_in(delta_in), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_s), .busy(busy_s), .done(done_s), .y_out(y_s)
  );

  nn_layer_engine #(.ACT(0)) u_lin (
    .clk(clk), .res(res), .start(start), .mode(mode), .x_in(x_in),
    .delta_in(delta_in), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_l), .busy(busy_l), .done(done_l), .y_out(y_l)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [31:0] yv(input logic [47:0] y, input int j);
    return 32'($signed(y[j*16 +: 16]));
  endfunction

  task automatic wr(input int a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = 4'(a); wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wrow(input int j, input logic [15:0] w0, w1, w2);
    wr(j*3, w0); wr(j*3+1, w1); wr(j*3+2, w2);
  endtask

  // Issue one command; the edge inside is the accepting edge t0.
  task automatic go(input logic [1:0] m, input logic [15:0] x0, x1, d0);
    mode = m; x_in = {x1, x0}; delta_in = {32'h0, d0}; start = 1'b1;
    tick();
    start = 1'b0; x_in = '0; delta_in = '0;
  endtask

  // Cycle index c0 is the current cycle, counting the one after t0 as 1.
  task automatic run(input int c0, output int cyc, output int bcnt);
    cyc = c0; bcnt = 0;
    while (!done_s && cyc < 60) begin
      bcnt += int'(busy_s);
      tick();
      cyc++;
    end
    if (done_s) begin
      chk("busy_at_done", 32'(busy_s), 0);
      chk("lin_done", 32'(done_l), 1);
    end
    tick();
  endtask

  task automatic rdchk(input string tag, input int a, input logic signed [31:0] e);
    rd_addr = 4'(a);
    #1;
    chk(tag, 32'($signed(rd_s)), e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c, b, extra;

    // Reset state
    repeat (3) tick();
    chk("rst_busy", 32'(busy_s), 0);
    chk("rst_done", 32'(done_s), 0);
    for (int j = 0; j < 3; j++) chk("rst_y", yv(y_s, j), 0);
    rdchk("rst_w0", 0, 0);
    res = 1'b1;
    tick();

    // Forward at defaults
    wrow(0, 16'd1024, 16'd1024, 16'd0);
    go(2'b00, 16'd512, 16'd256, 16'd0);
    run(1, c, b);
    chk("fwd_cyc", c, 13);
    chk("fwd_busy", b, 12);
    chk("fwd_y0", yv(y_s, 0), 704);
    chk("fwd_y1", yv(y_s, 1), 512);
    chk("fwd_lin_y0", yv(y_l, 0), 768);

    // Update, issued in the cycle right after done
    go(2'b01, 16'd512, 16'd256, 16'd512);
    run(1, c, b);
    chk("upd_cyc", c, 10);
    chk("upd_busy", b, 9);
    rdchk("upd_w00", 0, 992);
    chk("upd_w00_lin", 32'($signed(rd_l)), 992);
    rdchk("upd_w01", 1, 1008);
    rdchk("upd_w02", 2, -64);
    rdchk("upd_w10", 3, 0);
    rdchk("rd_oor", 15, 0);
    chk("upd_y_kept", yv(y_s, 0), 704);

    // Saturation, positive then negative
    wrow(0, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    go(2'b00, 16'h7FFF, 16'h7FFF, 16'd0);
    run(1, c, b);
    chk("sat_pos_lin", yv(y_l, 0), 32767);
    chk("sat_pos_sig", yv(y_s, 0), 1024);
    wrow(0, 16'h8000, 16'h8000, 16'h8000);
    go(2'b00, 16'h7FFF, 16'h7FFF, 16'd0);
    run(1, c, b);
    chk("sat_neg_lin", yv(y_l, 0), -32768);
    chk("sat_neg_sig", yv(y_s, 0), 0);

    // Hard-sigmoid clamp at acc = +/-4096
    wrow(0, 16'd4096, 16'd0, 16'd0);
    go(2'b00, 16'd1024, 16'd0, 16'd0);
    run(1, c, b);
    chk("hs_pos_lin", yv(y_l, 0), 4096);
    chk("hs_pos_sig", yv(y_s, 0), 1024);
    go(2'b00, 16'hFC00, 16'd0, 16'd0);
    run(1, c, b);
    chk("hs_neg_lin", yv(y_l, 0), -4096);
    chk("hs_neg_sig", yv(y_s, 0), 0);

    // start while busy: neither restarts nor queues
    go(2'b00, 16'd1024, 16'd0, 16'd0);
    tick(); tick();
    start = 1'b1; mode = 2'b00;
    tick();
    start = 1'b0;
    run(4, c, b);
    chk("busy_start_cyc", c, 13);
    extra = 0;
    repeat (20) begin tick(); extra += int'(done_s); end
    chk("busy_start_extra_done", extra, 0);

    // Reserved mode is ignored
    mode = 2'b10; start = 1'b1;
    tick();
    start = 1'b0; mode = 2'b00;
    chk("rsv_busy", 32'(busy_s), 0);
    extra = 0;
    repeat (15) begin tick(); extra += int'(busy_s) + int'(done_s); end
    chk("rsv_activity", extra, 0);

    // Write while busy is dropped
    go(2'b00, 16'd1024, 16'd0, 16'd0);
    tick();
    wr(0, 16'd7);
    run(3, c, b);
    chk("wr_busy_cyc", c, 13);
    rdchk("wr_busy_w00", 0, 4096);

    // Write and start on the same IDLE edge: command sees the new weight
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'd2048;
    mode = 2'b00; x_in = {16'd0, 16'd1024}; start = 1'b1;
    tick();
    wr_en = 1'b0; start = 1'b0; x_in = '0;
    run(1, c, b);
    chk("wr_start_lin_y0", yv(y_l, 0), 2048);
    rdchk("wr_start_w00", 0, 2048);

    // Reset in cycle 5 of a forward command
    wrow(0, 16'd1024, 16'd1024, 16'd0);
    go(2'b00, 16'd512, 16'd256, 16'd0);
    repeat (4) tick();
    res = 1'b0;
    tick();
    chk("mid_rst_busy", 32'(busy_s), 0);
    chk("mid_rst_busy_lin", 32'(busy_l), 0);
    chk("mid_rst_done", 32'(done_s), 0);
    for (int j = 0; j < 3; j++) begin
      chk("mid_rst_y", yv(y_s, j), 0);
      chk("mid_rst_y_lin", yv(y_l, j), 0);
    end
    for (int a = 0; a < 9; a++) rdchk("mid_rst_w", a, 0);
    res = 1'b1;
    tick();
    wrow(0, 16'd1024, 16'd1024, 16'd0);
    go(2'b00, 16'd512, 16'd256, 16'd0);
    run(1, c, b);
    chk("post_rst_cyc", c, 13);
    chk("post_rst_y0", yv(y_s, 0), 704);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
